// File: rtl/mem_initiator.sv
// mem_initiator
// Processor-side bus master for the single-port valid/ready memory. Accepts
// read, write and burst commands and sequences them onto the memory
// handshake as REQ -> RELEASE beats. Each beat produces a one-cycle
// response. A timeout guard aborts a beat whose memory never answers.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (accepted only in IDLE)
//   cmd_wr, cmd_addr,           command direction, start address,
//   cmd_wdata, cmd_len          beat-0 write data, beat count (0 means 1)
//   rsp_valid, rsp_rdata,       one-cycle response per beat: read data,
//   rsp_addr, rsp_err           beat address, timeout flag
//   busy                        FSM not in IDLE
//   valid, wr_rd, addr, wdata   memory request side
//   rdata, ready                memory response side (ready is registered
//                               by the memory)

module mem_initiator #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready
);

  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [LEN_W-1:0]   beats_left;
  logic [7:0]         timer;
  logic               accept;
  logic               beat_ok;
  logic               beat_err;
  logic               advance;

  // A command is only taken once a stale ready has gone away, so a beat
  // that follows a reset in the middle of a handshake cannot be answered
  // by the leftover acknowledge.
  assign cmd_ready = (state == IDLE) && !ready && !rst;
  assign busy      = (state != IDLE);
  assign valid     = (state == REQ);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and beat event decode. beats_left is decremented when a
  // beat leaves REQ, so in RELEASE it already counts the beats still owed.
  // The timeout fires on the TIMEOUT-th consecutive REQ cycle without
  // ready, i.e. when the counter still shows TIMEOUT-1.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    beat_ok    = 1'b0;
    beat_err   = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ready) begin
          beat_ok    = 1'b1;
          state_next = RELEASE;
        end else if (timer == TIMER_LAST) begin
          beat_err   = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!ready) begin
          if (beats_left != '0) begin
            advance    = 1'b1;
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request datapath and beat bookkeeping. Address wraps naturally because
  // DEPTH is a power of two; write data steps by one per beat modulo
  // 2^WIDTH, which equals cmd_wdata plus the beat index.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_rd      <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      beats_left <= '0;
      timer      <= '0;
    end else begin
      if (accept) begin
        wr_rd      <= cmd_wr;
        addr       <= cmd_addr;
        wdata      <= cmd_wdata;
        beats_left <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
      end
      if (beat_ok) begin
        beats_left <= beats_left - LEN_W'(1);
      end
      if (beat_err) begin
        beats_left <= '0;
      end
      if (advance) begin
        addr  <= addr + ADDR_WIDTH'(1);
        wdata <= wdata + WIDTH'(1);
      end
      // Counter runs only while waiting in REQ; any other state clears it,
      // so every REQ entry starts from zero.
      if ((state == REQ) && !ready) begin
        timer <= timer + 8'd1;
      end else begin
        timer <= '0;
      end
    end
  end

  // Registered one-cycle response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= beat_ok || beat_err;
      rsp_err   <= beat_err;
      rsp_rdata <= (beat_ok && !wr_rd) ? rdata : '0;
      rsp_addr  <= (beat_ok || beat_err) ? addr : '0;
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator
// Self-checking bench for mem_initiator. A behavioural single-port memory
// (ready registered one cycle behind valid, optional stuck-at-0 ready)
// sits on the memory side. Expected responses, with their cycle of arrival,
// are pushed to a queue when commands are accepted and popped by a monitor
// on every rsp_valid pulse.

module tb_mem_initiator;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int TO    = 15;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_wdata;
  logic [AW:0]   cmd_len;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic [AW-1:0] rsp_addr;
  logic          rsp_err;
  logic          busy;
  logic          valid;
  logic          wr_rd;
  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic [7:0]    rdata = 8'h00;
  logic          ready = 1'b0;

  logic          stuck0 = 1'b0;
  logic [7:0]    mem     [DEPTH];
  logic [7:0]    ref_mem [DEPTH];

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    rdata;
    logic          err;
    int            cyc;
  } exp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [AW:0]   len;
    int            beats;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  mem_initiator #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_len(cmd_len),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_addr(rsp_addr),
    .rsp_err(rsp_err),
    .busy(busy),
    .valid(valid),
    .wr_rd(wr_rd),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: samples valid on every edge, so each beat executes twice.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 7 + 3);
  end

  always @(posedge clk) begin
    if (stuck0) begin
      ready <= 1'b0;
    end else begin
      ready <= valid;
      if (valid) begin
        rdata <= mem[addr];
        if (wr_rd) mem[addr] <= wdata;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  // Response monitor and stale-ready guard.
  initial begin
    exp_t e;
    logic valid_d;
    valid_d = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_rsp", 32'(rsp_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_cycle", cyc, e.cyc);
          checkOutput("rsp_addr", 32'(rsp_addr), 32'(e.addr));
          checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      if (valid === 1'b1 && valid_d !== 1'b1) begin
        checkOutput("req_start_ready_low", 32'(ready), 32'd0);
      end
      valid_d = valid;
    end
  end

  task automatic issueCmd(input logic wr, input logic [AW-1:0] a,
                          input logic [7:0] d, input logic [AW:0] len,
                          output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_ready_seen", 32'(n < 100), 32'd1);
    if (n < 100) begin
      cmd_wr    = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_len   = len;
      cmd_valid = 1'b1;
      acc = cyc;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_done", 32'(n < budget), 32'd1);
    exp_q.delete();
  endtask

  // Issue one command and queue the expected beats from the reference
  // memory; writes update the reference as they are queued.
  task automatic applyStimulus(input vec_t v);
    int acc;
    exp_t e;
    logic [AW-1:0] a;
    issueCmd(v.wr, v.addr, v.wdata, v.len, acc);
    if (acc >= 0) begin
      for (int i = 0; i < v.beats; i++) begin
        a = v.addr + AW'(i);
        e.addr = a;
        e.err  = 1'b0;
        e.cyc  = acc + 3 + 4 * i;
        if (v.wr) begin
          e.rdata    = 8'h00;
          ref_mem[a] = v.wdata + 8'(i);
        end else begin
          e.rdata = ref_mem[a];
        end
        exp_q.push_back(e);
      end
      drain(4 * v.beats + 40);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int acc2;
    int n;
    exp_t e;

    vecs[0] = '{1'b1, 5'd5,  8'hA5, 6'd1,  1};
    vecs[1] = '{1'b0, 5'd5,  8'h00, 6'd1,  1};
    vecs[2] = '{1'b1, 5'd30, 8'h10, 6'd4,  4};
    vecs[3] = '{1'b0, 5'd30, 8'h00, 6'd4,  4};
    vecs[4] = '{1'b0, 5'd31, 8'h00, 6'd0,  1};
    vecs[5] = '{1'b1, 5'd10, 8'hFF, 6'd3,  3};
    vecs[6] = '{1'b0, 5'd10, 8'h00, 6'd3,  3};
    vecs[7] = '{1'b0, 5'd0,  8'h00, 6'd32, 32};

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 7 + 3);

    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_len   = '0;
    rst       = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_addr", 32'(addr), 32'd0);
    checkOutput("rst_wdata", 32'(wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Table-driven commands: write/read, wrapping burst, len 0, max length.
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Back-to-back single reads with cmd_valid held high.
    @(negedge clk);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    cmd_wr    = 1'b0;
    cmd_addr  = 5'd2;
    cmd_len   = 6'd1;
    cmd_valid = 1'b1;
    acc = cyc;
    e = '{5'd2, ref_mem[2], 1'b0, acc + 3};
    exp_q.push_back(e);
    @(posedge clk);
    #1 cmd_addr = 5'd3;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    acc2 = cyc;
    e = '{5'd3, ref_mem[3], 1'b0, acc2 + 3};
    exp_q.push_back(e);
    checkOutput("b2b_accept_gap", acc2 - acc, 32'd5);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    drain(40);

    // Timeout: ready stuck low, 3-beat read collapses to one error beat.
    stuck0 = 1'b1;
    issueCmd(1'b0, 5'd4, 8'h00, 6'd3, acc);
    e = '{5'd4, 8'h00, 1'b1, acc + 1 + TO};
    exp_q.push_back(e);
    drain(60);
    repeat (10) @(negedge clk);
    checkOutput("timeout_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    stuck0 = 1'b0;

    // Reset in the first REQ cycle of beat 2 of an 8-beat write.
    for (int i = 19; i < 24; i++) ref_mem[i] = mem[i];
    issueCmd(1'b1, 5'd16, 8'h40, 6'd8, acc);
    e = '{5'd16, 8'h00, 1'b0, acc + 3};
    exp_q.push_back(e);
    e = '{5'd17, 8'h00, 1'b0, acc + 7};
    exp_q.push_back(e);
    ref_mem[16] = 8'h40;
    ref_mem[17] = 8'h41;
    n = 0;
    while (cyc < acc + 9 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_in_req", 32'(valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_valid_low", 32'(valid), 32'd0);
    checkOutput("midrst_busy_low", 32'(busy), 32'd0);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("midrst_rsp_drained", exp_q.size(), 32'd0);
    checkOutput("midrst_mem16", 32'(mem[16]), 32'h40);
    checkOutput("midrst_mem17", 32'(mem[17]), 32'h41);
    for (int i = 19; i < 24; i++) begin
      checkOutput("midrst_mem_untouched", 32'(mem[i]), 32'(ref_mem[i]));
    end
    exp_q.delete();

    // Normal operation after the reset.
    applyStimulus('{1'b0, 5'd16, 8'h00, 6'd2, 2});

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
